// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants (Q3.4 operands) and the neuron MAC state encoding.
package nn_fixed_pkg;

  localparam int DATA_W  = 8;
  localparam int FRAC_W  = 4;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_FINISH = 2'd1,
    ST_OUT    = 2'd2
  } mac_state_e;

endpackage

// File: rtl/neuron_mac_sat.sv
// Combinational post-processing: bias add, arithmetic (floor) right shift and
// clamp of the Q7.8-scaled accumulator back to a Q3.4 byte.
module neuron_mac_sat
  #(
    parameter int ACC_W  = 18,
    parameter int FRAC_W = nn_fixed_pkg::FRAC_W
  ) (
    input  logic signed [ACC_W-1:0]               acc_i,
    input  logic signed [nn_fixed_pkg::DATA_W-1:0] bias_i,
    output logic signed [nn_fixed_pkg::DATA_W-1:0] z_o
  );
  import nn_fixed_pkg::*;

  // One spare bit so the bias add can never wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(SAT_MIN);

  logic signed [SUM_W-1:0] bias_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] shr_s;

  // Bias is aligned to the product scale before the add; the shift floors.
  always_comb begin
    bias_s = SUM_W'(bias_i) <<< FRAC_W;
    sum_s  = SUM_W'(acc_i) + bias_s;
    shr_s  = sum_s >>> FRAC_W;
    if (shr_s > MAX_S) begin
      z_o = DATA_W'(SAT_MAX);
    end else if (shr_s < MIN_S) begin
      z_o = DATA_W'(SAT_MIN);
    end else begin
      z_o = shr_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: sums N_INPUTS signed Q3.4 products, adds bias and
// hands a saturated Q3.4 pre-activation to the sigmoid stage via valid/ready.
module neuron_mac
  #(
    parameter int N_INPUTS = 4,
    parameter int FRAC_W   = nn_fixed_pkg::FRAC_W
  ) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic signed [nn_fixed_pkg::DATA_W-1:0] x_in,
    input  logic signed [nn_fixed_pkg::DATA_W-1:0] w_in,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [nn_fixed_pkg::DATA_W-1:0] bias,
    output logic signed [nn_fixed_pkg::DATA_W-1:0] z_value,
    output logic                                   z_valid,
    input  logic                                   z_ready
  );
  import nn_fixed_pkg::*;

  localparam int ACC_W = 16 + $clog2(N_INPUTS) + 2;
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  mac_state_e              state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    in_ready_q;
  logic                    z_valid_q;
  logic signed [DATA_W-1:0] z_value_q;
  logic signed [DATA_W-1:0] z_d;
  logic signed [15:0]      prod_s;
  logic                    accept_s;

  assign accept_s = in_valid & in_ready_q;
  assign prod_s   = 16'(x_in) * 16'(w_in);
  assign acc_d    = acc_q + ACC_W'(prod_s);

  neuron_mac_sat #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_sat (
    .acc_i  (acc_q),
    .bias_i (bias),
    .z_o    (z_d)
  );

  // Control FSM with accumulator, counter and all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      z_valid_q  <= 1'b0;
      z_value_q  <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s) begin
            acc_q <= acc_d;
            if (cnt_q == CNT_LAST) begin
              state_q    <= ST_FINISH;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FINISH: begin
          z_value_q <= z_d;
          z_valid_q <= 1'b1;
          state_q   <= ST_OUT;
        end
        ST_OUT: begin
          if (z_ready) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            z_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_ACCUM;
          end
        end
        default: begin
          state_q    <= ST_ACCUM;
          acc_q      <= '0;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
          z_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign z_valid  = z_valid_q;
  assign z_value  = z_value_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: expected z values come from an integer model,
// are queued when pairs are driven and compared when the result handshake occurs.
module tb_neuron_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x_in, w_in, bias, z_value;
  logic       in_valid, in_ready, z_valid, z_ready;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];

  neuron_mac #(.N_INPUTS(4), .FRAC_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_in     (x_in),
    .w_in     (w_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bias     (bias),
    .z_value  (z_value),
    .z_valid  (z_valid),
    .z_ready  (z_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] w,
                                       input logic [7:0] b, input int n);
    int s;
    s = n * int'($signed(x)) * int'($signed(w)) + int'($signed(b)) * 16;
    s = s >>> 4;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] w, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      x_in = x;
      w_in = w;
      in_valid = 1'b1;
      tick();
      if (gapped) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (z_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(z_valid), 32'd1);
  endtask

  task automatic wait_result(input string tag);
    wait_valid(tag);
    tick();
  endtask

  // Scoreboard side: a result is consumed whenever valid and ready meet.
  always @(negedge clk) begin
    if (rst === 1'b0 && z_valid === 1'b1 && z_ready === 1'b1) begin
      if (sb_q.size() == 0) check("z_valid_unexpected", 32'(z_valid), 32'd0);
      else check("z_value", 32'(z_value), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = 8'h00; w_in = 8'h00; bias = 8'h00; z_ready = 1'b1;
    tick();
    tick();
    check("rst_z_valid", 32'(z_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_z_value", 32'(z_value), 32'd0);
    rst = 1'b0;

    // Basic evaluation with exact latency checks.
    sb_q.push_back(model(8'h10, 8'h08, 8'h00, 4));
    send(8'h10, 8'h08, 4, 1'b0);
    check("lat_t1_z_valid", 32'(z_valid), 32'd0);
    check("lat_t1_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("lat_t2_z_valid", 32'(z_valid), 32'd1);
    check("lat_t2_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("post_out_in_ready", 32'(in_ready), 32'd1);
    check("post_out_z_valid", 32'(z_valid), 32'd0);
    check("retain_z_value", 32'(z_value), 32'(model(8'h10, 8'h08, 8'h00, 4)));

    // Saturation at both rails.
    sb_q.push_back(model(8'h7F, 8'h7F, 8'h00, 4));
    send(8'h7F, 8'h7F, 4, 1'b0);
    wait_result("sat_pos_done");
    sb_q.push_back(model(8'h7F, 8'h80, 8'h00, 4));
    send(8'h7F, 8'h80, 4, 1'b0);
    wait_result("sat_neg_done");

    // Floor shift and bias add.
    sb_q.push_back(model(8'hFF, 8'h01, 8'h00, 4));
    send(8'hFF, 8'h01, 4, 1'b0);
    wait_result("floor_done");
    bias = 8'h10;
    sb_q.push_back(model(8'hFF, 8'h01, 8'h10, 4));
    send(8'hFF, 8'h01, 4, 1'b0);
    wait_result("bias_done");
    bias = 8'h00;

    // Backpressure: result held three cycles while junk pairs are offered.
    z_ready = 1'b0;
    sb_q.push_back(model(8'h10, 8'h08, 8'h00, 4));
    send(8'h10, 8'h08, 4, 1'b0);
    wait_valid("bp_valid");
    for (int i = 0; i < 3; i++) begin
      x_in = 8'h7F;
      w_in = 8'h7F;
      in_valid = 1'b1;
      check("bp_z_valid", 32'(z_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_z_value", 32'(z_value), 32'(sb_q[0]));
      tick();
    end
    in_valid = 1'b0;
    z_ready = 1'b1;
    tick();
    sb_q.push_back(model(8'h10, 8'h08, 8'h00, 4));
    send(8'h10, 8'h08, 4, 1'b0);
    wait_result("bp_next_done");

    // Reset in the middle of an accumulation discards the partial sum.
    send(8'h10, 8'h10, 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_z_valid", 32'(z_valid), 32'd0);
    sb_q.push_back(model(8'h10, 8'h04, 8'h00, 4));
    send(8'h10, 8'h04, 4, 1'b0);
    wait_result("midrst_done");

    // Gapped input stream gives the same result as back-to-back.
    sb_q.push_back(model(8'h10, 8'h08, 8'h00, 4));
    send(8'h10, 8'h08, 4, 1'b1);
    wait_result("gapped_done");

    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N_INPUTS, default 4, number of (x, w) pairs per neuron evaluation (range 1..64).
REQ-002 Parameter FRAC_W, default 4, fractional bits of all 8-bit signed operands (Q3.4).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 x_in  input  8  signed input activation, Q3.4.
REQ-006 w_in  input  8  signed weight, Q3.4.
REQ-007 in_valid  input  1  x_in/w_in pair valid.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 bias  input  8  signed bias, Q3.4, sampled in FINISH only.
REQ-010 z_value  output  8  signed pre-activation result, Q3.4; feeds the sigmoid LUT/interpolator stage.
REQ-011 z_valid  output  1  z_value valid.
REQ-012 z_ready  input  1  downstream accepts z_value.

Function
REQ-013 The FSM SHALL have three states: ACCUM, FINISH, OUT.
REQ-014 ACCUM: in_ready=1; on in_valid&in_ready, acc += x_in*w_in (signed 16-bit Q7.8 product, sign-extended) and cnt += 1.
REQ-015 ACCUM -> FINISH on the cycle the N_INPUTS-th pair is accepted (cnt == N_INPUTS-1 at acceptance).
REQ-016 FINISH (exactly one cycle): in_ready=0; sum = acc + (sign-extended bias << FRAC_W); z_value <= saturate(sum >>> FRAC_W); go to OUT.
REQ-017 Shift SHALL be arithmetic (floor toward minus infinity); no rounding.
REQ-018 Saturation SHALL clamp to [-128, 127] (0x80..0x7F).
REQ-019 Accumulator width SHALL be 16 + clog2(N_INPUTS) + 2 bits; no internal overflow is permitted for any input.
REQ-020 OUT: z_valid=1, in_ready=0; z_value held stable; on z_ready, clear acc and cnt, go to ACCUM.
REQ-021 Latency: last pair accepted in cycle t -> z_valid=1 in cycle t+2.
REQ-022 z_value SHALL retain the last result after OUT until the next FINISH.
REQ-023 Pairs presented while in_ready=0 SHALL be ignored without side effect.
REQ-024 N_INPUTS=1: the first accepted pair SHALL transition directly to FINISH.
REQ-025 Maximum throughput: one result per N_INPUTS+2 cycles when z_ready is held 1.

Reset
REQ-026 On rst=1: state=ACCUM, acc=0, cnt=0, z_value=0x00, z_valid=0, in_ready=1 in the following cycle.
REQ-027 rst SHALL override all other inputs, including mid-accumulation and during OUT; partial sums are discarded.

Structure
REQ-028 A shared package nn_fixed_pkg SHALL hold DATA_W=8, FRAC_W=4, SAT_MAX=127, SAT_MIN=-128 and the FSM state enumeration.
REQ-029 One combinational sub-module neuron_mac_sat SHALL perform the bias add, arithmetic shift and saturation; the FSM, counter and accumulator stay in neuron_mac.

Verification
REQ-030 Basic: N=4, x=0x10, w=0x08, bias=0x00, z_ready=1 -> z_value=0x20, z_valid high exactly 2 cycles after the 4th pair.
REQ-031 Saturation: x=0x7F, w=0x7F (x4) -> 0x7F; x=0x7F, w=0x80 (x4) -> 0x80.
REQ-032 Floor/bias: x=0xFF, w=0x01 (x4), bias=0x00 -> 0xFF; same pairs with bias=0x10 -> 0x0F.
REQ-033 Backpressure: z_ready=0 for 3 cycles in OUT -> z_valid and z_value stable, in_ready=0, in_valid pairs ignored; result accepted on the 4th cycle, next evaluation unaffected.
REQ-034 Reset mid-operation: 2 pairs (x=0x10, w=0x10), rst for 1 cycle, then 4 pairs x=0x10, w=0x04 -> z_value=0x10.
REQ-035 Gapped input: in_valid toggled 1/0 per cycle -> same z_value as the back-to-back case (0x20 with the REQ-030 data).
